// File: rtl/l1_cache.sv
// Direct-mapped, write-through, write-allocate L1 data cache with a word-wide
// CPU port and a single outstanding block transaction towards L2.
module l1_cache #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 11,
    parameter int CACHE_SIZE = 128,
    parameter int BLOCK_SIZE = 32
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [ADDR_WIDTH-1:0]            cpu_addr,
    input  logic [DATA_WIDTH-1:0]            cpu_wdata,
    input  logic                             cpu_read,
    input  logic                             cpu_write,
    output logic [DATA_WIDTH-1:0]            cpu_rdata,
    output logic                             cpu_ready,
    output logic                             cpu_hit,
    output logic [ADDR_WIDTH-1:0]            l2_addr,
    output logic [BLOCK_SIZE*DATA_WIDTH-1:0] l2_data_out,
    output logic                             l2_read,
    output logic                             l2_write,
    input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] l2_data_in,
    input  logic                             l2_block_valid,
    input  logic                             l2_ready
);

    localparam int LINES    = CACHE_SIZE / BLOCK_SIZE;
    localparam int OFFSET_W = $clog2(BLOCK_SIZE);
    localparam int INDEX_W  = $clog2(LINES);
    localparam int TAG_W    = ADDR_WIDTH - INDEX_W - OFFSET_W;
    localparam int BLK_W    = BLOCK_SIZE * DATA_WIDTH;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        RD_REQ,
        RD_WAIT,
        WR_REQ,
        WR_WAIT
    } state_t;

    state_t                  r_state;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic                    r_is_write;
    logic                    r_hit;
    logic                    r_cnt;
    logic [LINES-1:0]        r_valid;
    logic [TAG_W-1:0]        r_tag  [LINES];
    logic [BLK_W-1:0]        r_data [LINES];

    logic [OFFSET_W-1:0]     w_offset;
    logic [INDEX_W-1:0]      w_index;
    logic [TAG_W-1:0]        w_tag;
    logic [ADDR_WIDTH-1:0]   w_blk_addr;
    logic [BLK_W-1:0]        w_line;
    logic                    w_hit;
    logic [DATA_WIDTH-1:0]   w_line_word;
    logic [DATA_WIDTH-1:0]   w_fill_word;
    logic [BLK_W-1:0]        w_merged_line;
    logic [BLK_W-1:0]        w_merged_fill;
    logic                    w_rd_accept;
    logic                    w_wr_accept;
    logic                    w_arr_we;
    logic [BLK_W-1:0]        w_arr_wdata;

    assign w_offset   = r_addr[OFFSET_W-1:0];
    assign w_index    = r_addr[OFFSET_W +: INDEX_W];
    assign w_tag      = r_addr[ADDR_WIDTH-1 -: TAG_W];
    assign w_blk_addr = {r_addr[ADDR_WIDTH-1:OFFSET_W], {OFFSET_W{1'b0}}};
    assign w_line     = r_data[w_index];
    assign w_hit      = r_valid[w_index] && (r_tag[w_index] == w_tag);

    // l2_ready only counts once the strobe has been up for its second cycle.
    assign w_rd_accept = l2_ready && ((r_state == RD_REQ && r_cnt) || r_state == RD_WAIT);
    assign w_wr_accept = l2_ready && ((r_state == WR_REQ && r_cnt) || r_state == WR_WAIT);

    always_comb begin
        w_line_word   = '0;
        w_fill_word   = '0;
        w_merged_line = w_line;
        w_merged_fill = l2_data_in;
        for (int unsigned w = 0; w < BLOCK_SIZE; w++) begin
            if (w_offset == OFFSET_W'(w)) begin
                w_line_word = w_line[w*DATA_WIDTH +: DATA_WIDTH];
                w_fill_word = l2_data_in[w*DATA_WIDTH +: DATA_WIDTH];
                w_merged_line[w*DATA_WIDTH +: DATA_WIDTH] = r_wdata;
                w_merged_fill[w*DATA_WIDTH +: DATA_WIDTH] = r_wdata;
            end
        end
    end

    always_comb begin
        w_arr_we    = 1'b0;
        w_arr_wdata = w_merged_line;
        if (r_state == LOOKUP && r_is_write && w_hit) begin
            w_arr_we = 1'b1;
        end else if (w_rd_accept && l2_block_valid) begin
            w_arr_we    = 1'b1;
            w_arr_wdata = r_is_write ? w_merged_fill : l2_data_in;
        end
    end

    // Tag and data arrays carry no reset; only the valid bits do.
    always_ff @(posedge clk) begin
        if (w_arr_we) begin
            r_tag[w_index]  <= w_tag;
            r_data[w_index] <= w_arr_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_is_write  <= 1'b0;
            r_hit       <= 1'b0;
            r_cnt       <= 1'b0;
            r_valid     <= '0;
            cpu_rdata   <= '0;
            cpu_ready   <= 1'b0;
            cpu_hit     <= 1'b0;
            l2_addr     <= '0;
            l2_data_out <= '0;
            l2_read     <= 1'b0;
            l2_write    <= 1'b0;
        end else begin
            cpu_ready <= 1'b0;
            cpu_hit   <= 1'b0;
            l2_read   <= 1'b0;
            l2_write  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (cpu_read || cpu_write) begin
                        r_addr     <= cpu_addr;
                        r_wdata    <= cpu_wdata;
                        r_is_write <= cpu_write;
                        r_state    <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    r_cnt <= 1'b0;
                    if (!r_is_write && w_hit) begin
                        cpu_rdata <= w_line_word;
                        cpu_ready <= 1'b1;
                        cpu_hit   <= 1'b1;
                        r_state   <= IDLE;
                    end else if (r_is_write && w_hit) begin
                        l2_data_out <= w_merged_line;
                        l2_addr     <= w_blk_addr;
                        l2_write    <= 1'b1;
                        r_hit       <= 1'b1;
                        r_state     <= WR_REQ;
                    end else begin
                        l2_addr <= w_blk_addr;
                        l2_read <= 1'b1;
                        r_hit   <= 1'b0;
                        r_state <= RD_REQ;
                    end
                end
                RD_REQ, RD_WAIT: begin
                    if (w_rd_accept) begin
                        r_cnt <= 1'b0;
                        if (!l2_block_valid) begin
                            r_valid[w_index] <= 1'b0;
                            cpu_rdata        <= '0;
                            cpu_ready        <= 1'b1;
                            r_state          <= IDLE;
                        end else begin
                            r_valid[w_index] <= 1'b1;
                            if (r_is_write) begin
                                l2_data_out <= w_merged_fill;
                                l2_write    <= 1'b1;
                                r_state     <= WR_REQ;
                            end else begin
                                cpu_rdata <= w_fill_word;
                                cpu_ready <= 1'b1;
                                r_state   <= IDLE;
                            end
                        end
                    end else if (r_state == RD_REQ) begin
                        if (!r_cnt) begin
                            l2_read <= 1'b1;
                            r_cnt   <= 1'b1;
                        end else begin
                            r_state <= RD_WAIT;
                        end
                    end
                end
                WR_REQ, WR_WAIT: begin
                    if (w_wr_accept) begin
                        cpu_ready <= 1'b1;
                        cpu_hit   <= r_hit;
                        r_state   <= IDLE;
                    end else if (r_state == WR_REQ) begin
                        if (!r_cnt) begin
                            l2_write <= 1'b1;
                            r_cnt    <= 1'b1;
                        end else begin
                            r_state <= WR_WAIT;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/l1_cache.md
Name: l1_cache

Overview:
- Direct-mapped, write-through, write-allocate L1 data cache with a word-wide CPU port.
- Sits directly upstream of the L2 cache and exchanges whole blocks with it over the L2 block interface.
- Serves read hits locally with no L2 traffic.
- Read misses and all writes go to L2 as single-outstanding block transactions.

Parameters:
- DATA_WIDTH, 32: word width in bits.
- ADDR_WIDTH, 11: word address width; must match L2.
- CACHE_SIZE, 128: capacity in words.
- BLOCK_SIZE, 32: words per block; must match L2.
- Derived: LINES = CACHE_SIZE/BLOCK_SIZE (4), OFFSET_W = clog2(BLOCK_SIZE) (5), INDEX_W = clog2(LINES) (2), TAG_W = ADDR_WIDTH-INDEX_W-OFFSET_W (4).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cpu_addr  in  ADDR_WIDTH  word address.
- cpu_wdata  in  DATA_WIDTH  write word.
- cpu_read  in  1  read request.
- cpu_write  in  1  write request.
- cpu_rdata  out  DATA_WIDTH  read word, valid with cpu_ready.
- cpu_ready  out  1  one-cycle completion pulse.
- cpu_hit  out  1  with cpu_ready: access hit in L1.
- l2_addr  out  ADDR_WIDTH  block-aligned address, offset bits 0.
- l2_data_out  out  BLOCK_SIZE*DATA_WIDTH  block to L2; word w at [w*DATA_WIDTH +: DATA_WIDTH].
- l2_read  out  1  block read strobe.
- l2_write  out  1  block write strobe.
- l2_data_in  in  BLOCK_SIZE*DATA_WIDTH  block from L2, same packing.
- l2_block_valid  in  1  l2_data_in valid.
- l2_ready  in  1  L2 transaction complete, one-cycle pulse.

Behaviour:
- Reset (async, rst_n=0): state IDLE; all valid bits 0; all outputs 0. Tags and data are not reset. Reset mid-transaction abandons it with no cpu_ready; L2 is reset with the same rst_n.
- Address split: offset=[OFFSET_W-1:0]; index=next INDEX_W bits; tag=upper TAG_W bits.
- All outputs are registered. cpu_ready, cpu_hit, l2_read and l2_write default to 0 every cycle unless driven.
- States: IDLE, LOOKUP, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT.
- IDLE: samples cpu_read|cpu_write and captures addr, wdata and op into request registers, then goes to LOOKUP. The CPU may drop the request after it is sampled. If read and write are both set, the request is treated as a write. No request → stay in IDLE.
- LOOKUP, read hit: cpu_rdata=line word, cpu_ready=1, cpu_hit=1, go to IDLE. cpu_ready is high in the cycle after LOOKUP, i.e. the 2nd edge after sampling.
- LOOKUP, read miss: l2_read=1, l2_addr={tag,index,0}, go to RD_REQ.
- LOOKUP, write hit: merge cpu_wdata into the line at offset (array updated now). Set l2_data_out=merged line, l2_addr, l2_write=1, latch hit=1, go to WR_REQ.
- LOOKUP, write miss: l2_read=1 as for a read miss, latch hit=0, go to RD_REQ (fetch first).
- L2 strobe rule: l2_read/l2_write stays high for exactly 2 consecutive cycles. RD_REQ/WR_REQ hold it one more cycle via a 1-bit counter, then the state goes to *_WAIT. l2_addr and l2_data_out are held stable until l2_ready is sampled.
- l2_ready is accepted in RD_REQ's 2nd cycle or in RD_WAIT; likewise in WR_REQ's 2nd cycle or in WR_WAIT.
- Read completion, l2_ready with l2_block_valid=1: fill line (tag, data, valid=1).
  - Read op: cpu_rdata=fetched word, cpu_ready=1, cpu_hit=0, go to IDLE.
  - Write op: merge cpu_wdata into the fetched block and fill the line with the merged block. Issue l2_write with the merged block, go to WR_REQ.
- Read completion, l2_ready with l2_block_valid=0: no fill, line valid bit cleared. cpu_ready=1, cpu_rdata=0, cpu_hit=0, go to IDLE; a write op is dropped.
- Write completion: on l2_ready in WR_WAIT, cpu_ready=1, cpu_hit=latched hit, go to IDLE. l2_block_valid is ignored here.
- Replacement: direct-mapped overwrite; no dirty state, because write-through keeps L2 current.
- Single outstanding request; cpu_read/cpu_write are ignored outside IDLE.
- l2_ready arriving in IDLE or LOOKUP is ignored.

Test Plan:
- Reset, read 0x045; L2 returns word i = 0x1000+i after 3 cycles → l2_read high exactly 2 cycles with l2_addr=0x040, then cpu_ready with cpu_rdata=0x1005, cpu_hit=0.
- Then read 0x047 → cpu_ready on the 2nd edge after sampling, cpu_rdata=0x1007, cpu_hit=1, l2_read never asserted.
- Write 0x046 = 0xDEADBEEF (hit) → l2_write high 2 cycles, l2_addr=0x040, word6=0xDEADBEEF, word5=0x1005. cpu_ready and cpu_hit=1 follow l2_ready. A subsequent read 0x046 hits with 0xDEADBEEF.
- Write 0x0C3 = 0x12345678 (same index 2, tag 1, miss) → l2_read at 0x0C0, then l2_write at 0x0C0 with word3=0x12345678, cpu_hit=0. A subsequent read 0x045 misses.
- Assert rst_n=0 while in RD_WAIT → all outputs 0 immediately, no cpu_ready. Read 0x047 after release misses (l2_read asserted).
- cpu_read=cpu_write=1 at 0x045 with wdata 0xA5A5A5A5 → handled as a write: l2_write is issued and cpu_rdata is not updated. l2_ready with l2_block_valid=0 on a read miss → cpu_ready, cpu_rdata=0, line stays invalid.
